// File: rtl/polar_g_serial_unit.sv
// Bit-serial polar-decoder g-function stage.
// Computes llr_out = u ? (llr_b - llr_a) : (llr_b + llr_a), one bit per cycle,
// LSB first. The result is saturated to a symmetric range of +/-(2^(W-1)-1).
//
// state  | meaning
// IDLE   | waiting for an operand set, in_ready=1
// SHIFT  | W cycles of serial add/subtract, one result bit per cycle
// DONE   | result presented with out_valid=1 until out_ready
module polar_g_serial_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] llr_a,
    input  logic [W-1:0] llr_b,
    input  logic         u_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] llr_out,
    output logic         sat
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [W-1:0]  POS_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_MAX  = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    logic [1:0]    state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          borrow;
    logic          u_r;

    logic          x;
    logic          y;
    logic          sum_bit;
    logic          diff_bit;
    logic          carry_next;
    logic          borrow_next;
    logic [W-1:0]  raw;
    logic          ovf;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // One-bit full adder / subtractor cell plus overflow detection on the final bit.
    // On the last SHIFT cycle the shifters hold the original sign bits in bit 0,
    // so x/y double as sign(b)/sign(a) for the saturation check.
    always_comb begin
        x           = b_sh[0];
        y           = a_sh[0];
        sum_bit     = x ^ y ^ carry;
        diff_bit    = x ^ y ^ borrow;
        carry_next  = (x & y) | ((x ^ y) & carry);
        borrow_next = (~x & y) | (~(x ^ y) & borrow);
        raw         = {(u_r ? diff_bit : sum_bit), res[W-1:1]};
        if (u_r) begin
            ovf = (y != x) && (raw[W-1] != x);
        end else begin
            ovf = (y == x) && (raw[W-1] != x);
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            borrow  <= 1'b0;
            u_r     <= 1'b0;
            llr_out <= '0;
            sat     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= llr_a;
                        b_sh   <= llr_b;
                        u_r    <= u_bit;
                        carry  <= 1'b0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    carry  <= carry_next;
                    borrow <= borrow_next;
                    res    <= raw;
                    a_sh   <= {1'b0, a_sh[W-1:1]};
                    b_sh   <= {1'b0, b_sh[W-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        if (ovf) begin
                            llr_out <= x ? NEG_MAX : POS_MAX;
                            sat     <= 1'b1;
                        end else if (raw == MOST_NEG) begin
                            llr_out <= NEG_MAX;
                            sat     <= 1'b1;
                        end else begin
                            llr_out <= raw;
                            sat     <= 1'b0;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polar_g_serial_unit.sv
// Self-checking bench for polar_g_serial_unit (W=8): vector table plus
// hand-written sequences for backpressure and mid-operation reset.
module tb_polar_g_serial_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] llr_a;
    logic [W-1:0] llr_b;
    logic         u_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] llr_out;
    logic         sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         u;
        logic [W-1:0] exp_out;
        logic         exp_sat;
    } vec_t;

    vec_t vecs[12];

    polar_g_serial_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .llr_a     (llr_a),
        .llr_b     (llr_b),
        .u_bit     (u_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .llr_out   (llr_out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for out_valid after the accept edge; returns edges elapsed since it.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic u, input logic [W-1:0] exp_out, input logic exp_sat);
        int lat;
        @(negedge clk);
        check({name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        llr_a    = a;
        llr_b    = b;
        u_bit    = u;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        llr_a    = ~a;
        llr_b    = ~b;
        u_bit    = ~u;
        check({name, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        check({name, " latency"}, lat, W);
        check({name, " llr_out"}, {24'd0, llr_out}, {24'd0, exp_out});
        check({name, " sat"}, {31'd0, sat}, {31'd0, exp_sat});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " back to idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_out;
        logic         held_sat;

        vecs[0]  = '{8'd5,    8'd3,    1'b0, 8'h08, 1'b0};
        vecs[1]  = '{8'd5,    8'd3,    1'b1, 8'hFE, 1'b0};
        vecs[2]  = '{8'd100,  8'd100,  1'b0, 8'h7F, 1'b1};
        vecs[3]  = '{8'd100,  8'h9C,   1'b1, 8'h81, 1'b1};
        vecs[4]  = '{8'h80,   8'd0,    1'b0, 8'h81, 1'b1};
        vecs[5]  = '{8'hFF,   8'hFF,   1'b1, 8'h00, 1'b0};
        vecs[6]  = '{8'h9C,   8'h9C,   1'b0, 8'h81, 1'b1};
        vecs[7]  = '{8'hC0,   8'hC0,   1'b0, 8'h81, 1'b1};
        vecs[8]  = '{8'd127,  8'd0,    1'b1, 8'h81, 1'b0};
        vecs[9]  = '{8'h80,   8'd0,    1'b1, 8'h7F, 1'b1};
        vecs[10] = '{8'd7,    8'hFE,   1'b0, 8'h05, 1'b0};
        vecs[11] = '{8'hCE,   8'd20,   1'b1, 8'h46, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        llr_a     = '0;
        llr_b     = '0;
        u_bit     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset llr_out", {24'd0, llr_out}, 32'd0);
        check("reset sat", {31'd0, sat}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].u,
                   vecs[i].exp_out, vecs[i].exp_sat);
        end

        // Backpressure: result held in DONE, inputs ignored, then a same-cycle accept on return to IDLE.
        @(negedge clk);
        llr_a = 8'd100; llr_b = 8'd100; u_bit = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp latency", lat, W);
        held_out = llr_out;
        held_sat = sat;
        check("bp llr_out", {24'd0, held_out}, 32'h7F);
        check("bp sat", {31'd0, held_sat}, 32'd1);
        @(negedge clk);
        llr_a = 8'd20; llr_b = 8'd10; u_bit = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp hold%0d llr_out", k), {24'd0, llr_out}, 32'h7F);
            check($sformatf("bp hold%0d sat", k), {31'd0, sat}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        check("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        check("bp idle llr_out kept", {24'd0, llr_out}, 32'h7F);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp new accept", {31'd0, in_ready}, 32'd0);
        u_bit = 1'b0;
        wait_valid(lat);
        check("bp new latency", lat, W);
        check("bp new llr_out", {24'd0, llr_out}, 32'hF6);
        check("bp new sat", {31'd0, sat}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset on the third SHIFT cycle aborts the operation.
        @(negedge clk);
        llr_a = 8'd100; llr_b = 8'd100; u_bit = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst llr_out", {24'd0, llr_out}, 32'd0);
        check("rst sat", {31'd0, sat}, 32'd0);
        lat = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("rst no out_valid", lat, 0);
        run_op("post rst", 8'd7, 8'hFE, 1'b0, 8'h05, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
